// File: rtl/psram_arbiter_pkg.sv
// Shared types and the round-robin search helper for the psram arbiter.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package psram_arbiter_pkg;

    localparam int MAX_PORTS = 8;
    localparam int IDX_BITS  = $clog2(MAX_PORTS);

    // Sized for the largest supported port count so one type serves every instance.
    typedef logic [IDX_BITS-1:0] port_idx_t;

    // First set bit of req at or after last+1, wrapping modulo num.
    function automatic port_idx_t rr_first(input logic [MAX_PORTS-1:0] req,
                                           input port_idx_t            last,
                                           input int                   num);
        port_idx_t pick;
        logic      found;
        int        k;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            k = (int'(last) + i) % num;
            if (!found && (i <= num) && req[port_idx_t'(k)]) begin
                found = 1'b1;
                pick  = port_idx_t'(k);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester-side and controller-side signals of the psram arbiter.
// Latency: none (wiring only).
// Backpressure: requests are levels held until the matching ack.
interface psram_arbiter_if #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDRESS_BITS = 23,
    parameter int DATA_BITS    = 16
);
    logic [NUM_PORTS-1:0]    req_rd_en;
    logic [ADDRESS_BITS-1:0] req_rd_address [NUM_PORTS];
    logic [NUM_PORTS-1:0]    req_rd_ack;
    logic [NUM_PORTS-1:0]    req_rd_valid;
    logic [DATA_BITS-1:0]    req_rd_data;
    logic [NUM_PORTS-1:0]    req_wr_en;
    logic [ADDRESS_BITS-1:0] req_wr_address [NUM_PORTS];
    logic [DATA_BITS-1:0]    req_wr_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]    req_wr_ack;

    logic                    mem_rd_en;
    logic [ADDRESS_BITS-1:0] mem_rd_address;
    logic                    mem_rd_ack;
    logic [DATA_BITS-1:0]    mem_rd_data;
    logic                    mem_wr_en;
    logic [ADDRESS_BITS-1:0] mem_wr_address;
    logic [DATA_BITS-1:0]    mem_wr_data;
    logic                    mem_wr_ack;

    modport slave (
        input  req_rd_en, req_rd_address, req_wr_en, req_wr_address, req_wr_data,
        input  mem_rd_ack, mem_rd_data, mem_wr_ack,
        output req_rd_ack, req_rd_valid, req_rd_data, req_wr_ack,
        output mem_rd_en, mem_rd_address, mem_wr_en, mem_wr_address, mem_wr_data
    );

    modport master (
        output req_rd_en, req_rd_address, req_wr_en, req_wr_address, req_wr_data,
        output mem_rd_ack, mem_rd_data, mem_wr_ack,
        input  req_rd_ack, req_rd_valid, req_rd_data, req_wr_ack,
        input  mem_rd_en, mem_rd_address, mem_wr_en, mem_wr_address, mem_wr_data
    );
endinterface

// File: rtl/psram_arbiter_rr_picker.sv
// Combinational round-robin pick among requesting ports, starting after last_i.
// Latency: zero cycles.
// Backpressure: none; the pick is re-evaluated every cycle.
module rr_picker
    import psram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  port_idx_t            last_i,
    output logic                 grant_vld_o,
    output logic [NUM_PORTS-1:0] grant_oh_o,
    output port_idx_t            grant_idx_o
);

    logic [MAX_PORTS-1:0] req_pad;

    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_PORTS-1:0]   = req_i;
        grant_vld_o              = |req_i;
        grant_idx_o              = rr_first(req_pad, last_i, NUM_PORTS);
        grant_oh_o               = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_oh_o[i] = grant_vld_o && (grant_idx_o == port_idx_t'(i));
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one psram controller between NUM_PORTS read/write requesters, round-robin.
// Latency: acks combinational; read data valid READ_LATENCY+1 cycles after rd ack.
// Backpressure: requests hold until acked; only one read return is tracked at a time.
module psram_arbiter
    import psram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int ADDRESS_BITS = 23,
    parameter int DATA_BITS    = 16,
    parameter bit WRITE_WINS   = 1'b1,
    parameter int READ_LATENCY = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    psram_arbiter_if.slave  bus,
    output logic            overlap_error
);

    localparam int SEL_BITS = $clog2(NUM_PORTS);
    localparam int CNT_BITS = $clog2(READ_LATENCY + 1);

    typedef logic [SEL_BITS-1:0] sel_t;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] is_wr;
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 grant_vld;
    port_idx_t            grant_idx;
    sel_t                 sel;
    logic                 any_ack;

    port_idx_t            last_grant_q, last_grant_d;
    logic [CNT_BITS-1:0]  pend_cnt_q, pend_cnt_d;
    sel_t                 pend_port_q, pend_port_d;
    logic [NUM_PORTS-1:0] rd_vld_q, rd_vld_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 overlap_q, overlap_d;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i]   = bus.req_rd_en[i] | bus.req_wr_en[i];
            is_wr[i] = bus.req_wr_en[i] & (WRITE_WINS | ~bus.req_rd_en[i]);
        end
    end

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req_i       (req),
        .last_i      (last_grant_q),
        .grant_vld_o (grant_vld),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx)
    );

    // With no requester the mux parks on port 0.
    assign sel = grant_vld ? sel_t'(grant_idx) : '0;

    assign bus.mem_wr_en      = grant_vld & is_wr[sel];
    assign bus.mem_rd_en      = grant_vld & ~is_wr[sel];
    assign bus.mem_rd_address = bus.req_rd_address[sel];
    assign bus.mem_wr_address = bus.req_wr_address[sel];
    assign bus.mem_wr_data    = bus.req_wr_data[sel];

    assign bus.req_rd_ack = grant_oh & {NUM_PORTS{bus.mem_rd_ack}};
    assign bus.req_wr_ack = grant_oh & {NUM_PORTS{bus.mem_wr_ack}};

    assign any_ack = grant_vld & (bus.mem_rd_ack | bus.mem_wr_ack);

    always_comb begin
        last_grant_d = any_ack ? grant_idx : last_grant_q;
        pend_cnt_d   = pend_cnt_q;
        pend_port_d  = pend_port_q;
        rd_vld_d     = '0;
        rd_data_d    = rd_data_q;
        overlap_d    = overlap_q;

        if (pend_cnt_q != '0) begin
            pend_cnt_d = pend_cnt_q - CNT_BITS'(1);
        end
        if (pend_cnt_q == CNT_BITS'(1)) begin
            rd_data_d              = bus.mem_rd_data;
            rd_vld_d[pend_port_q]  = 1'b1;
        end
        // A new read reloads the tracker; if the old one is mid-flight its return is lost.
        if (bus.mem_rd_ack) begin
            pend_cnt_d  = CNT_BITS'(READ_LATENCY);
            pend_port_d = sel;
            if (pend_cnt_q > CNT_BITS'(1)) begin
                overlap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= port_idx_t'(NUM_PORTS - 1);
            pend_cnt_q   <= '0;
            pend_port_q  <= '0;
            rd_vld_q     <= '0;
            rd_data_q    <= '0;
            overlap_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_port_q  <= pend_port_d;
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
            overlap_q    <= overlap_d;
        end
    end

    assign bus.req_rd_valid = rd_vld_q;
    assign bus.req_rd_data  = rd_data_q;
    assign overlap_error    = overlap_q;

endmodule
